// File: rtl/msi_drop_fifo.sv
// msi_drop_fifo: drop-word FIFO between the fabric drop path and the avalon
// fabric cluster. The write side has no back-pressure; a word arriving while
// full with no simultaneous pop is discarded and flagged in a sticky overflow.
//
// Parameters:
//   DEPTH      entry count, power of two, >= 4
//   AF_THRESH  almost-full level, 1..DEPTH
//
// Ports:
//   clk                sole clock, rising edge
//   reset              synchronous active-high reset
//   fab_drop_in_bus80  incoming drop word
//   fab_drop_in_vld    incoming word present this cycle
//   fab_drop_in_afull  fill level >= AF_THRESH
//   df_af_fabbus80     registered head word
//   df_af_vld          registered head-valid
//   df_af_rdy          consumer accepts head word
//   df_fill_cnt        number of stored words (0..DEPTH)
//   df_ovf             sticky overflow flag
//   df_ovf_clr         clears df_ovf (a same-cycle overflow wins)
//   df_drop_cnt        saturating discarded-word count, only when the macro
//                      MSI_DROP_FIFO_STATS_EN is defined
module msi_drop_fifo #(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AF_THRESH = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [79:0]              fab_drop_in_bus80,
    input  logic                     fab_drop_in_vld,
    output logic                     fab_drop_in_afull,
    output logic [79:0]              df_af_fabbus80,
    output logic                     df_af_vld,
    input  logic                     df_af_rdy,
    output logic [$clog2(DEPTH):0]   df_fill_cnt,
    output logic                     df_ovf,
    input  logic                     df_ovf_clr
`ifdef MSI_DROP_FIFO_STATS_EN
    ,
    output logic [15:0]              df_drop_cnt
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [79:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [79:0]   head_q, head_d;
    logic          vld_q;
    logic          ovf_q, ovf_d;
    logic          push, pop, full, drop;

    always_comb begin
        pop      = vld_q && df_af_rdy;
        full     = (cnt_q == CW'(DEPTH));
        push     = fab_drop_in_vld && (!full || pop);
        drop     = fab_drop_in_vld && full && !pop;

        // Pointers are AW bits wide, so DEPTH-1 wraps to 0 naturally.
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        // Pre-compute next head word. When the word being written lands on the
        // next read slot (fill becomes exactly 1 via this push) the array does
        // not hold it yet, so bypass the input bus into the output register.
        head_d = head_q;
        if (cnt_d != '0) begin
            if (push && (wr_ptr_q == rd_ptr_d)) begin
                head_d = fab_drop_in_bus80;
            end else begin
                head_d = mem[rd_ptr_d];
            end
        end

        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (df_ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            head_q   <= '0;
            vld_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            head_q   <= head_d;
            vld_q    <= (cnt_d != '0);
            ovf_q    <= ovf_d;
        end
    end

    // Storage is not reset; gated on !reset so a reset cycle stores nothing.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wr_ptr_q] <= fab_drop_in_bus80;
        end
    end

`ifdef MSI_DROP_FIFO_STATS_EN
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_cnt_q <= '0;
        end else if (df_ovf_clr) begin
            drop_cnt_q <= drop ? 16'd1 : 16'd0;
        end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign df_drop_cnt = drop_cnt_q;
`endif

    assign fab_drop_in_afull = (cnt_q >= CW'(AF_THRESH));
    assign df_af_fabbus80    = head_q;
    assign df_af_vld         = vld_q;
    assign df_fill_cnt       = cnt_q;
    assign df_ovf            = ovf_q;

endmodule

// File: tb/tb_msi_drop_fifo.sv
// tb_msi_drop_fifo: directed sequence plus a randomized phase, compared each
// cycle against a queue-based reference model of the drop FIFO.
module tb_msi_drop_fifo;

    localparam int unsigned DEPTH     = 16;
    localparam int unsigned AF_THRESH = 12;
    localparam int unsigned CW        = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic [79:0]   fab_drop_in_bus80;
    logic          fab_drop_in_vld;
    logic          fab_drop_in_afull;
    logic [79:0]   df_af_fabbus80;
    logic          df_af_vld;
    logic          df_af_rdy;
    logic [CW-1:0] df_fill_cnt;
    logic          df_ovf;
    logic          df_ovf_clr;
`ifdef MSI_DROP_FIFO_STATS_EN
    logic [15:0]   df_drop_cnt;
`endif

    msi_drop_fifo #(
        .DEPTH     (DEPTH),
        .AF_THRESH (AF_THRESH)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .fab_drop_in_bus80 (fab_drop_in_bus80),
        .fab_drop_in_vld   (fab_drop_in_vld),
        .fab_drop_in_afull (fab_drop_in_afull),
        .df_af_fabbus80    (df_af_fabbus80),
        .df_af_vld         (df_af_vld),
        .df_af_rdy         (df_af_rdy),
        .df_fill_cnt       (df_fill_cnt),
        .df_ovf            (df_ovf),
        .df_ovf_clr        (df_ovf_clr)
`ifdef MSI_DROP_FIFO_STATS_EN
        ,
        .df_drop_cnt       (df_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state
    logic [79:0] q[$];
    logic        m_ovf = 1'b0;
    logic [15:0] m_drops = '0;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("fill_cnt", 80'(df_fill_cnt), 80'(q.size()));
        chk("vld", 80'(df_af_vld), 80'(q.size() != 0));
        if (q.size() != 0) chk("head", df_af_fabbus80, q[0]);
        chk("afull", 80'(fab_drop_in_afull), 80'(q.size() >= AF_THRESH));
        chk("ovf", 80'(df_ovf), 80'(m_ovf));
`ifdef MSI_DROP_FIFO_STATS_EN
        chk("drop_cnt", 80'(df_drop_cnt), 80'(m_drops));
`endif
    endtask

    // One clock: drive inputs, advance the model, check after the edge.
    task automatic step(input logic v, input logic [79:0] d, input logic r,
                        input logic c, input logic rs);
        logic m_pop, m_full, m_push, m_drop;
        fab_drop_in_vld   = v;
        fab_drop_in_bus80 = d;
        df_af_rdy         = r;
        df_ovf_clr        = c;
        reset             = rs;
        if (rs) begin
            q.delete();
            m_ovf   = 1'b0;
            m_drops = '0;
        end else begin
            m_pop  = r && (q.size() != 0);
            m_full = (q.size() == DEPTH);
            m_push = v && (!m_full || m_pop);
            m_drop = v && m_full && !m_pop;
            if (m_pop) void'(q.pop_front());
            if (m_push) q.push_back(d);
            if (m_drop) m_ovf = 1'b1;
            else if (c) m_ovf = 1'b0;
            if (c) m_drops = m_drop ? 16'd1 : 16'd0;
            else if (m_drop && m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        fab_drop_in_vld   = 1'b0;
        fab_drop_in_bus80 = '0;
        df_af_rdy         = 1'b0;
        df_ovf_clr        = 1'b0;
        reset             = 1'b1;

        // Reset state
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
        chk("rst_head_zero", df_af_fabbus80, 80'h0);
        chk("rst_vld_zero", 80'(df_af_vld), 80'h0);

        // Push 0x1..0xA without reading; rdy while empty is ignored first
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 10; i++) step(1'b1, 80'(i), 1'b0, 1'b0, 1'b0);
        chk("fill10", 80'(df_fill_cnt), 80'd10);
        chk("fill10_afull", 80'(fab_drop_in_afull), 80'd0);
        chk("fill10_head", df_af_fabbus80, 80'h1);

        // Fill to 16, then a 17th push overflows
        for (int i = 11; i <= 16; i++) step(1'b1, 80'(i), 1'b0, 1'b0, 1'b0);
        chk("full_cnt", 80'(df_fill_cnt), 80'd16);
        step(1'b1, 80'h99, 1'b0, 1'b0, 1'b0);
        chk("ovf_set", 80'(df_ovf), 80'd1);
        chk("ovf_head_kept", df_af_fabbus80, 80'h1);

        // Clear, then push together with a pop at full
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 80'h11, 1'b1, 1'b0, 1'b0);
        chk("full_pushpop_cnt", 80'(df_fill_cnt), 80'd16);
        chk("full_pushpop_ovf", 80'(df_ovf), 80'd0);

        // Drain (model checks order: 2..16 then 0x11)
        for (int i = 0; i < 18; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Stream 40 words with continuous rdy: fill stays at most 1
        for (int i = 1; i <= 40; i++) begin
            step(1'b1, 80'(i), 1'b1, 1'b0, 1'b0);
            chk("stream_fill_le1", 80'(df_fill_cnt <= 1), 80'd1);
        end
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Overflow and clear in the same cycle: overflow wins
        for (int i = 0; i < 16; i++) step(1'b1, 80'(100 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 80'hBAD, 1'b0, 1'b1, 1'b0);
        chk("ovf_clr_same", 80'(df_ovf), 80'd1);
        step(1'b0, '0, 1'b0, 1'b1, 1'b0);
        chk("ovf_clr_only", 80'(df_ovf), 80'd0);

        // Reset at fill 7 with push and pop active
        step(1'b1, 80'h0, 1'b1, 1'b0, 1'b1);
        for (int i = 1; i <= 7; i++) step(1'b1, 80'(200 + i), 1'b0, 1'b0, 1'b0);
        chk("pre_rst_fill7", 80'(df_fill_cnt), 80'd7);
        step(1'b1, 80'h777, 1'b1, 1'b0, 1'b1);
        chk("mid_rst_cnt", 80'(df_fill_cnt), 80'd0);
        chk("mid_rst_vld", 80'(df_af_vld), 80'd0);

        // Randomized phase
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 99) < 65),
                 {16'($urandom), $urandom, $urandom},
                 ($urandom_range(0, 99) < 45),
                 ($urandom_range(0, 99) < 5),
                 ($urandom_range(0, 199) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/msi_drop_fifo.md
MSI_DROP_FIFO -- requirements
Module: msi_drop_fifo

Interface
REQ-001 Parameter DEPTH, default 16, entry count; SHALL be a power of two, minimum 4.
REQ-002 Parameter AF_THRESH, default 12, almost-full level; SHALL satisfy 1 <= AF_THRESH <= DEPTH.
REQ-003 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 fab_drop_in_bus80  in  80  drop word from fabric.
REQ-006 fab_drop_in_vld  in  1  drop word present this cycle; no back-pressure on this side.
REQ-007 fab_drop_in_afull  out  1  fill level at or above AF_THRESH.
REQ-008 df_af_fabbus80  out  80  head word presented to the avalon fabric cluster.
REQ-009 df_af_vld  out  1  df_af_fabbus80 holds a valid word.
REQ-010 df_af_rdy  in  1  consumer accepts the head word.
REQ-011 df_fill_cnt  out  log2(DEPTH)+1  current number of stored words.
REQ-012 df_ovf  out  1  sticky overflow flag.
REQ-013 df_ovf_clr  in  1  clears df_ovf.

Function
REQ-014 Push SHALL occur when fab_drop_in_vld=1 and (fifo not full, or a pop occurs in the same cycle).
REQ-015 Pop SHALL occur when df_af_vld=1 and df_af_rdy=1.
REQ-016 Simultaneous push and pop SHALL leave df_fill_cnt unchanged, including at full and at fill 1.
REQ-017 A push into an empty fifo SHALL raise df_af_vld on the next cycle; there is no same-cycle fall-through.
REQ-018 df_af_fabbus80 and df_af_vld SHALL be registered outputs.
REQ-019 While df_af_vld=1 and df_af_rdy=0, df_af_fabbus80 SHALL hold stable.
REQ-020 Words SHALL leave in arrival order.
REQ-021 Read and write pointers SHALL wrap from DEPTH-1 to 0 without a gap cycle.
REQ-022 df_fill_cnt SHALL range 0..DEPTH, increment on push-only, decrement on pop-only.
REQ-023 fab_drop_in_afull SHALL equal (df_fill_cnt >= AF_THRESH), derived from the registered count.
REQ-024 A push attempt when full with no pop SHALL discard the word, leave the stored contents intact, and set df_ovf on the next edge.
REQ-025 If df_ovf_clr=1, df_ovf SHALL clear on the next edge; a same-cycle overflow SHALL win and keep df_ovf set.
REQ-026 df_af_rdy asserted while df_af_vld=0 SHALL be ignored.

Reset
REQ-027 After reset, the following SHALL hold: df_af_vld=0, df_af_fabbus80=0, df_fill_cnt=0, fab_drop_in_afull=0, df_ovf=0, both pointers=0.
REQ-028 Reset asserted mid-operation SHALL discard all stored words on that edge, overriding any push or pop in the same cycle.
REQ-029 Storage array contents need not be reset.

Configuration
REQ-030 Macro MSI_DROP_FIFO_STATS_EN defined: add output df_drop_cnt (16 bits), which SHALL increment once per discarded word, saturate at 16'hFFFF, clear on reset, and clear on df_ovf_clr (a same-cycle drop counts as 1).
REQ-031 Macro MSI_DROP_FIFO_STATS_EN undefined: no df_drop_cnt port and no counter logic; all other behaviour SHALL be identical.

Verification
REQ-032 Reset, then push 0x1..0xA with df_af_rdy=0 -> df_fill_cnt=10, fab_drop_in_afull=0, df_af_fabbus80=0x1 held.
REQ-033 Push 6 more (to 16) with df_af_rdy=0 -> afull rises when the count reaches 12; count=16; a 17th push sets df_ovf (and df_drop_cnt=1 with the stats macro); head stays 0x1.
REQ-034 Full fifo, push 0x11 together with a pop -> count stays 16, 0x11 is accepted, df_ovf is not set by this push.
REQ-035 Stream 40 words with df_af_rdy=1 continuously -> output order 1..40 with no loss, pointers wrap twice, fill never exceeds 1.
REQ-036 Overflow and df_ovf_clr in the same cycle -> df_ovf=1; a clear-only cycle next -> df_ovf=0.
REQ-037 Reset asserted at fill 7 with a push active -> next cycle count=0, df_af_vld=0.
